instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch sequencer for the single-cycle datapath. It holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents each returned word with a valid/ready handshake. The control unit decodes opcode `instr[31:26]` from that word. Branch and jump decisions fed back from the datapath redirect the PC, so this block is the producing end of the opcode stream the control unit consumes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  read request to instruction memory; registered.
- `imem_addr`  out  32  read address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; ignored while `imem_req`=0.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `instr_valid`  out  1  `instr`/`pc_out` hold a fetched instruction.
- `instr`  out  32  fetched word; `[31:26]` drives control-unit opcode.
- `pc_out`  out  32  address of `instr`.
- `instr_ready`  in  1  datapath consumes `instr` this cycle.
- `branch_taken`  in  1  consumed instruction is a taken branch.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  consumed instruction is a jump.
- `jump_index`  in  26  jump field `instr[25:0]`.
- `misalign_fault`  out  1  sticky redirect-misalignment flag (see Configuration).

## Operation
- States: IDLE (reset), FETCH, HOLD, FAULT.
- IDLE -> FETCH unconditionally on the first edge after reset release. On that edge `imem_req`=1 and `imem_addr`=`RESET_PC`.
- FETCH:
  - `imem_req` is held at 1 and `imem_addr` is held stable until `imem_ack`.
  - On the `imem_ack` edge: `instr`<=`imem_rdata`, `pc_out`<=`imem_addr`, `instr_valid`<=1, `imem_req`<=0, -> HOLD.
- HOLD:
  - `instr`, `pc_out` and `instr_valid` are held until `instr_ready`=1.
  - On the consume edge: `instr_valid`<=0, `imem_req`<=1, `imem_addr`<=next PC, -> FETCH.
- Next PC, evaluated only on the consume edge:
  - `jump`: {(`pc_out`+4)[31:28], `jump_index`, 2'b00}.
  - else `branch_taken`: `branch_target`.
  - else: `pc_out`+4, wrapping modulo 2^32; 32'hFFFF_FFFC -> 32'h0.
  - `jump` wins when asserted together with `branch_taken`.
- Outside the consume edge, `branch_taken`, `jump` and the targets are don't-care and ignored.
- An outstanding request is never cancelled; a redirect only affects the next request.
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_valid`=0, `pc_out`=`RESET_PC`, `misalign_fault`=0, state IDLE.
- Reset asserted mid-request: the request is dropped immediately and the memory must tolerate the abandoned read. After release, fetch restarts at `RESET_PC`.

## Timing
- First request: `imem_req` rises 1 cycle after `rst_n` deasserts.
- Fetch latency: `instr_valid` rises the cycle after the `imem_ack` cycle.
- Zero-wait memory (ack in the first req cycle) plus `instr_ready` tied high gives 1 instruction per 2 cycles.
- `imem_req` is low for exactly the cycles in HOLD/IDLE/FAULT. It is never high in the same cycle as `instr_valid`.

## Configuration
- Macro: `IFU_MISALIGN_CHECK_EN`.
- Defined:
  - A selected redirect target (branch or jump) with `[1:0]`!=0 sets `misalign_fault`<=1 and moves to FAULT instead of FETCH.
  - FAULT keeps `imem_req`=0 and `instr_valid`=0 until reset.
  - A sequential PC can never misalign.
- Not defined:
  - Target bits `[1:0]` are forced to 0 and fetch continues.
  - `misalign_fault` is tied to 0 and FAULT is unreachable.

## Test plan
- Reset release, zero-wait memory, `instr_ready`=1 -> requests at 0x0, 0x4, 0x8 on cycles 1, 3, 5; `instr`=mem word each following cycle.
- Memory acks 3 cycles late at 0x4 -> `imem_addr` stays 0x4 and `imem_req` stays high all 3 cycles; `instr_valid` only after ack.
- HOLD with `instr_ready`=0 for 4 cycles -> `instr`/`pc_out` unchanged, no request issued; consume -> next request at `pc_out`+4.
- Consume at `pc_out`=0x1000_0010 with `jump`=1, `jump_index`=26'h40, `branch_taken`=1, `branch_target`=0x80 -> next address 0x1000_0100 (jump priority).
- `pc_out`=0xFFFF_FFFC consumed with no redirect -> next address 0x0.
- `branch_target`=0x82 taken -> with macro: `misalign_fault`=1 and no further requests; without macro: request at 0x80.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, reads words over req/ack and hands them to the datapath over valid/ready.
// Optional macro IFU_MISALIGN_CHECK_EN traps misaligned redirect targets in a sticky FAULT state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

    state_t      state, state_nxt;
    logic        req_nxt, valid_nxt, fault_nxt;
    logic [31:0] addr_nxt, instr_nxt, pc_nxt;
    logic [31:0] seq_pc, redirect_pc, target_pc;
    logic        redirect, misaligned;

    // Jump takes priority over a simultaneous taken branch.
    assign seq_pc      = pc_out + 32'd4;
    assign redirect    = jump | branch_taken;
    assign redirect_pc = jump ? {seq_pc[31:28], jump_index, 2'b00} : branch_target;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
    assign target_pc  = redirect ? redirect_pc : seq_pc;
`else
    logic unused_lsbs;
    assign unused_lsbs = ^redirect_pc[1:0];
    assign misaligned  = 1'b0;
    assign target_pc   = redirect ? {redirect_pc[31:2], 2'b00} : seq_pc;
`endif

    always_comb begin
        state_nxt = state;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        pc_nxt    = pc_out;
        fault_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
                addr_nxt  = RESET_PC;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_nxt = HOLD;
                    instr_nxt = imem_rdata;
                    pc_nxt    = imem_addr;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_nxt = 1'b0;
                    if (misaligned) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                        req_nxt   = 1'b1;
                        addr_nxt  = target_pc;
                    end
                end
            end
            FAULT: begin
                req_nxt   = 1'b0;
                valid_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            pc_out      <= RESET_PC;
        end else begin
            state       <= state_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            pc_out      <= pc_nxt;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_fault <= 1'b0;
        else if (fault_nxt)
            misalign_fault <= 1'b1;
    end
`else
    logic unused_fault;
    assign unused_fault   = fault_nxt;
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit; a program-order PC model predicts every request and instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        misalign_fault;

    typedef struct packed {
        logic        j;
        logic [25:0] idx;
        logic        b;
        logic [31:0] tgt;
    } redir_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    redir_t      redir_q[$];
    logic [31:0] model_pc = 32'h0;
    logic        model_fault = 1'b0;
    int          wait_cnt = 0;
    bit          tput_check = 1'b0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory content is a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Program-order PC model: next address from the consumed instruction's redirect fields.
    task automatic modelConsume(input logic j, input logic [25:0] idx, input logic b, input logic [31:0] tgt);
        logic [31:0] seq;
        logic [31:0] nxt;
        seq = model_pc + 32'd4;
        if (j)      nxt = {seq[31:28], idx, 2'b00};
        else if (b) nxt = tgt;
        else        nxt = seq;
`ifdef IFU_MISALIGN_CHECK_EN
        if (nxt[1:0] != 2'b00) begin
            model_fault = 1'b1;
            return;
        end
`else
        nxt[1:0] = 2'b00;
`endif
        model_pc = nxt;
        exp_addr_q.push_back(nxt);
        exp_pc_q.push_back(nxt);
    endtask

    task automatic applyStimulus(input int cycles, input int ack_pct, input int ready_pct, input int redir_pct);
        redir_t r;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (tput_check) checkOutput("tput_req", {31'b0, imem_req}, {31'b0, (i % 2) == 0});
            if (imem_req) begin
                imem_ack = (wait_cnt >= 3) || ($urandom_range(99) < ack_pct);
                wait_cnt = imem_ack ? 0 : wait_cnt + 1;
            end else begin
                imem_ack = 1'($urandom_range(1));
                wait_cnt = 0;
            end
            instr_ready   = ($urandom_range(99) < ready_pct);
            jump          = ($urandom_range(99) < redir_pct);
            branch_taken  = ($urandom_range(99) < redir_pct);
            jump_index    = 26'($urandom);
            branch_target = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
            branch_target[1:0] = 2'b00;
`endif
            if (instr_valid && instr_ready) begin
                if (redir_q.size() > 0) begin
                    r             = redir_q.pop_front();
                    jump          = r.j;
                    jump_index    = r.idx;
                    branch_taken  = r.b;
                    branch_target = r.tgt;
                end
                modelConsume(jump, jump_index, branch_taken, branch_target);
            end
        end
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_pc_out", pc_out, 32'h0);
        checkOutput("rst_misalign_fault", {31'b0, misalign_fault}, 32'h0);
        exp_addr_q.delete();
        exp_pc_q.delete();
        redir_q.delete();
        model_pc    = 32'h0;
        model_fault = 1'b0;
        wait_cnt    = 0;
        exp_addr_q.push_back(32'h0);
        exp_pc_q.push_back(32'h0);
        rst_n = 1'b1;
    endtask

    // Drop reset in the middle of an outstanding request and expect the request to vanish at once.
    task automatic resetMidRequest();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            applyStimulus(1, 0, 100, 0);
            if (imem_req && !imem_ack) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL mid_req_wait: got no open request in 20 cycles, required one");
        end else begin
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("async_reset_req", {31'b0, imem_req}, 32'h0);
        end
        doReset();
    endtask

    // Monitor: every rising request / rising valid pops the next expected address.
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr, prev_instr, prev_pc;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (imem_req) begin
                if (!prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_req: got request at 0x%08h, required no request", imem_addr);
                    end else begin
                        e = exp_addr_q.pop_front();
                        checkOutput("req_addr", imem_addr, e);
                    end
                end else begin
                    checkOutput("addr_stable", imem_addr, prev_addr);
                end
            end
            if (instr_valid) begin
                if (!prev_valid) begin
                    if (exp_pc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_instr: got instr at pc 0x%08h, required none", pc_out);
                    end else begin
                        e = exp_pc_q.pop_front();
                        checkOutput("pc_out", pc_out, e);
                        checkOutput("instr", instr, mem_word(e));
                    end
                end else begin
                    checkOutput("instr_held", instr, prev_instr);
                    checkOutput("pc_held", pc_out, prev_pc);
                end
            end
            checkOutput("req_valid_excl", {31'b0, imem_req & instr_valid}, 32'h0);
            prev_req   = imem_req;
            prev_valid = instr_valid;
            prev_addr  = imem_addr;
            prev_instr = instr;
            prev_pc    = pc_out;
        end
    end

    initial begin
        doReset();
        tput_check = 1'b1;
        applyStimulus(6, 100, 100, 0);
        tput_check = 1'b0;
        applyStimulus(20, 0, 100, 0);
        applyStimulus(12, 100, 0, 0);
        applyStimulus(6, 100, 100, 0);
        redir_q.push_back('{j: 1'b0, idx: 26'h0, b: 1'b1, tgt: 32'h1000_0010});
        redir_q.push_back('{j: 1'b1, idx: 26'h40, b: 1'b1, tgt: 32'h0000_0080});
        redir_q.push_back('{j: 1'b0, idx: 26'h0, b: 1'b1, tgt: 32'hFFFF_FFFC});
        redir_q.push_back('{j: 1'b0, idx: 26'h0, b: 1'b0, tgt: 32'h0});
        applyStimulus(16, 100, 100, 0);
        applyStimulus(1500, 60, 60, 30);
        resetMidRequest();
        applyStimulus(300, 60, 60, 30);
        redir_q.push_back('{j: 1'b0, idx: 26'h0, b: 1'b1, tgt: 32'h0000_0082});
        applyStimulus(12, 100, 100, 0);
        applyStimulus(8, 100, 0, 0);
        checkOutput("misalign_fault", {31'b0, misalign_fault}, {31'b0, model_fault});
        checkOutput("addr_q_drained", exp_addr_q.size(), 32'h0);
        checkOutput("pc_q_drained", exp_pc_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
